// File: rtl/march_bist_ctrl.sv
// March C- built-in self-test controller for a single-port synchronous RAM.
// Owns address, strobes and background while busy; records the first mismatch.
module march_bist_ctrl #(
    parameter int AD_W   = 4,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy,
    output logic              done,
    output logic              fail,
    output logic [AD_W-1:0]   mem_addr,
    output logic              mem_we,
    output logic              mem_re,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [AD_W-1:0]   fail_addr,
    output logic [2:0]        fail_elem,
    output logic [DATA_W-1:0] fail_data
);

    typedef enum logic [1:0] {IDLE, RD, CMP, DONE} state_t;

    localparam logic [AD_W-1:0] A_LAST = {AD_W{1'b1}};

    state_t            state_q, state_d;
    logic [2:0]        elem_q, elem_d;
    logic [AD_W-1:0]   addr_q, addr_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              fail_q, fail_d;
    logic              we_q, we_d;
    logic              re_q, re_d;
    logic [AD_W-1:0]   mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [AD_W-1:0]   fail_addr_q, fail_addr_d;
    logic [2:0]        fail_elem_q, fail_elem_d;
    logic [DATA_W-1:0] fail_data_q, fail_data_d;
    logic              at_end;

    function automatic logic [DATA_W-1:0] bg(input logic one);
        return {DATA_W{one}};
    endfunction

    // Elements M2 and M4 expect the all-ones background; the rest expect zeros.
    function automatic logic rd_one(input logic [2:0] e);
        return (e == 3'd2) || (e == 3'd4);
    endfunction

    function automatic logic wr_one(input logic [2:0] e);
        return (e == 3'd1) || (e == 3'd3);
    endfunction

    function automatic logic is_down(input logic [2:0] e);
        return (e == 3'd3) || (e == 3'd4);
    endfunction

    always_comb begin
        state_d     = state_q;
        elem_d      = elem_q;
        addr_d      = addr_q;
        fail_d      = fail_q;
        fail_addr_d = fail_addr_q;
        fail_elem_d = fail_elem_q;
        fail_data_d = fail_data_q;
        at_end      = is_down(elem_q) ? (addr_q == '0) : (addr_q == A_LAST);

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d     = CMP;
                    elem_d      = 3'd0;
                    addr_d      = '0;
                    fail_d      = 1'b0;
                    fail_addr_d = '0;
                    fail_elem_d = 3'd0;
                    fail_data_d = '0;
                end
            end
            RD: state_d = CMP;
            CMP: begin
                // M0 reuses the CMP state as a write-only cycle with no compare.
                if (elem_q == 3'd0) begin
                    if (addr_q == A_LAST) begin
                        state_d = RD;
                        elem_d  = 3'd1;
                        addr_d  = '0;
                    end else begin
                        addr_d = addr_q + 1'b1;
                    end
                end else if (mem_rdata != bg(rd_one(elem_q))) begin
                    state_d     = DONE;
                    fail_d      = 1'b1;
                    fail_addr_d = addr_q;
                    fail_elem_d = elem_q;
                    fail_data_d = mem_rdata;
                end else if (at_end) begin
                    if (elem_q == 3'd5) begin
                        state_d = DONE;
                    end else begin
                        state_d = RD;
                        elem_d  = elem_q + 3'd1;
                        addr_d  = is_down(elem_d) ? A_LAST : '0;
                    end
                end else begin
                    state_d = RD;
                    addr_d  = is_down(elem_q) ? addr_q - 1'b1 : addr_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d     = (state_d == RD) || (state_d == CMP);
        done_d     = (state_d == DONE);
        we_d       = (state_d == CMP) && (elem_d != 3'd5);
        re_d       = (state_d == RD);
        mem_addr_d = busy_d ? addr_d : '0;
        wdata_d    = we_d ? bg(wr_one(elem_d)) : '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            elem_q      <= 3'd0;
            addr_q      <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            fail_q      <= 1'b0;
            we_q        <= 1'b0;
            re_q        <= 1'b0;
            mem_addr_q  <= '0;
            wdata_q     <= '0;
            fail_addr_q <= '0;
            fail_elem_q <= 3'd0;
            fail_data_q <= '0;
        end else begin
            state_q     <= state_d;
            elem_q      <= elem_d;
            addr_q      <= addr_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            fail_q      <= fail_d;
            we_q        <= we_d;
            re_q        <= re_d;
            mem_addr_q  <= mem_addr_d;
            wdata_q     <= wdata_d;
            fail_addr_q <= fail_addr_d;
            fail_elem_q <= fail_elem_d;
            fail_data_q <= fail_data_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign fail      = fail_q;
    assign mem_addr  = mem_addr_q;
    assign mem_we    = we_q;
    assign mem_re    = re_q;
    assign mem_wdata = wdata_q;
    assign fail_addr = fail_addr_q;
    assign fail_elem = fail_elem_q;
    assign fail_data = fail_data_q;

endmodule

// File: tb/tb_march_bist_ctrl.sv
// Directed bench for march_bist_ctrl: behavioural RAM with an optional stuck-at cell.
module tb_march_bist_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic [7:0] mem_rdata = 8'h00;
    logic       busy, done, fail, mem_we, mem_re;
    logic [3:0] mem_addr, fail_addr;
    logic [7:0] mem_wdata, fail_data;
    logic [2:0] fail_elem;

    march_bist_ctrl #(.AD_W(4), .DATA_W(8)) dut (
        .clk(clk), .reset(reset), .start(start), .mem_rdata(mem_rdata),
        .busy(busy), .done(done), .fail(fail), .mem_addr(mem_addr),
        .mem_we(mem_we), .mem_re(mem_re), .mem_wdata(mem_wdata),
        .fail_addr(fail_addr), .fail_elem(fail_elem), .fail_data(fail_data)
    );

    always #5 clk = ~clk;

    // RAM model; the faulty cell forces bits through or_m / and_m on read.
    logic [7:0] mem [16];
    logic [3:0] f_addr = 4'd0;
    logic [7:0] or_m = 8'h00;
    logic [7:0] and_m = 8'hFF;

    always @(posedge clk) begin
        if (mem_we) mem[mem_addr] <= mem_wdata;
        if (mem_re) begin
            if (mem_addr == f_addr) mem_rdata <= (mem[mem_addr] | or_m) & and_m;
            else                    mem_rdata <= mem[mem_addr];
        end
    end

    int n_chk = 0;
    int n_pass = 0;
    int wr_a[$];
    int wr_d[$];
    int rd_a[$];
    int overlap;
    int post_acc;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Pulse start (unless already held), then log every cycle until done.
    task automatic run(input int inj_cyc, output int done_cyc, output int busy_cnt);
        wr_a.delete(); wr_d.delete(); rd_a.delete();
        overlap = 0; post_acc = 0; done_cyc = 0; busy_cnt = 0;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        for (int i = 1; i <= 400; i++) begin
            @(negedge clk);
            if (busy) busy_cnt++;
            if (mem_we) begin wr_a.push_back(int'(mem_addr)); wr_d.push_back(int'(mem_wdata)); end
            if (mem_re) rd_a.push_back(int'(mem_addr));
            if (mem_we && mem_re) overlap++;
            if (i == inj_cyc) start = 1'b1;
            else if (i == inj_cyc + 1) start = 1'b0;
            if (done) begin done_cyc = i; break; end
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (mem_we || mem_re) post_acc++;
        end
    endtask

    task automatic check_pass(input string tag, input int dc, input int bc);
        chk({tag, "_done_cyc"}, dc, 177);
        chk({tag, "_busy_cnt"}, bc, 176);
        chk({tag, "_fail"}, fail, 0);
        chk({tag, "_busy_after"}, busy, 0);
    endtask

    int dc, bc, bad;

    initial begin
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("rst_flags", {busy, done, fail, mem_we, mem_re}, 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_data", {mem_wdata, fail_data, fail_addr, fail_elem}, 0);

        // Fault-free run with full access logging
        run(-10, dc, bc);
        check_pass("pass", dc, bc);
        chk("pass_overlap", overlap, 0);
        chk("pass_post_acc", post_acc, 0);
        chk("pass_wr_cnt", wr_a.size(), 80);
        chk("pass_rd_cnt", rd_a.size(), 80);
        bad = (wr_a.size() >= 16) ? 0 : 1;
        if (wr_a.size() >= 16)
            for (int i = 0; i < 16; i++) if (wr_a[i] != i || wr_d[i] != 0) bad++;
        chk("m0_writes", bad, 0);
        bad = (rd_a.size() == 80) ? 0 : 1;
        if (rd_a.size() == 80)
            for (int i = 0; i < 16; i++) begin
                if (rd_a[i] != i)           bad++;
                if (rd_a[16 + i] != i)      bad++;
                if (rd_a[32 + i] != 15 - i) bad++;
                if (rd_a[48 + i] != 15 - i) bad++;
                if (rd_a[64 + i] != i)      bad++;
            end
        chk("rd_order", bad, 0);
        bad = (wr_a.size() == 80) ? 0 : 1;
        if (wr_a.size() == 80)
            for (int i = 0; i < 16; i++) begin
                if (wr_a[16 + i] != i || wr_d[16 + i] != 8'hFF)      bad++;
                if (wr_a[32 + i] != i || wr_d[32 + i] != 8'h00)      bad++;
                if (wr_a[48 + i] != 15 - i || wr_d[48 + i] != 8'hFF) bad++;
                if (wr_a[64 + i] != 15 - i || wr_d[64 + i] != 8'h00) bad++;
            end
        chk("wr_order", bad, 0);

        // Start pulse in the middle of a run is ignored
        run(20, dc, bc);
        check_pass("ign", dc, bc);

        // Start held high in DONE launches a new run next cycle
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("hold_done", done, 0);
        chk("hold_busy", busy, 1);
        chk("hold_we", mem_we, 1);
        repeat (3) @(negedge clk);
        start = 1'b0;

        // Reset mid-run clears every output
        repeat (45) @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("midrst_flags", {busy, done, fail, mem_we, mem_re}, 0);
        chk("midrst_addr", mem_addr, 0);
        chk("midrst_data", mem_wdata, 0);
        run(-10, dc, bc);
        check_pass("after_rst", dc, bc);

        // Address 5 bit 3 stuck-at-1: caught in M1
        f_addr = 4'd5; or_m = 8'h08; and_m = 8'hFF;
        run(-10, dc, bc);
        chk("sa1_done_cyc", dc, 29);
        chk("sa1_fail", fail, 1);
        chk("sa1_elem", fail_elem, 1);
        chk("sa1_addr", fail_addr, 5);
        chk("sa1_data", fail_data, 8'h08);
        chk("sa1_post_acc", post_acc, 0);

        // Address 0 bit 0 stuck-at-0: survives M0/M1, caught in M2
        f_addr = 4'd0; or_m = 8'h00; and_m = 8'hFE;
        run(-10, dc, bc);
        chk("sa0_done_cyc", dc, 51);
        chk("sa0_fail", fail, 1);
        chk("sa0_elem", fail_elem, 2);
        chk("sa0_addr", fail_addr, 0);
        chk("sa0_data", fail_data, 8'hFE);
        repeat (5) @(negedge clk);
        chk("sa0_hold", {done, fail, fail_elem, fail_data}, {1'b1, 1'b1, 3'd2, 8'hFE});

        // A new start clears the previous failure record
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        chk("restart_clr", {done, fail, fail_elem, fail_addr, fail_data}, 0);
        chk("restart_busy", busy, 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/march_bist_ctrl.md
Name: march_bist_ctrl

Overview:
- Built-in self-test controller for the single-port synchronous RAM that the address generator normally drives.
- Runs a March C- sequence over every address: owns its own address counter, read/write strobes and data background.
- Compares read data against the expected background and reports pass/fail with the first failing address, element and data.
- Sits beside the RAM; the system muxes its memory outputs onto the RAM while busy=1.

Parameters:
AD_W, 4, address width; depth N = 2**AD_W
DATA_W, 8, RAM data width; backgrounds are all-zeros (Z) and all-ones (O)

Ports:
clk  input  1  clock, rising edge
reset  input  1  synchronous, active-high
start  input  1  run request, sampled only when not busy
mem_rdata  input  DATA_W  RAM read data, valid the cycle after mem_re
busy  output  1  test in progress
done  output  1  test finished, held until next start or reset
fail  output  1  mismatch found, valid when done=1
mem_addr  output  AD_W  RAM address
mem_we  output  1  RAM write strobe
mem_re  output  1  RAM read strobe
mem_wdata  output  DATA_W  RAM write data
fail_addr  output  AD_W  address of first mismatch
fail_elem  output  3  march element (0-5) of first mismatch
fail_data  output  DATA_W  read data captured at first mismatch

Behaviour:
- One clock domain (clk); reset is synchronous and active-high. All outputs are registered.
- Reset, including mid-run: state IDLE; every output 0; address counter 0. Takes effect at the next edge.
- States: IDLE, RD, CMP, DONE. RD and CMP carry the current element number E (0-5) and cell address A.
- Elements:
  - M0: up, write Z.
  - M1: up, read Z then write O.
  - M2: up, read O then write Z.
  - M3: down, read Z then write O.
  - M4: down, read O then write Z.
  - M5: up, read Z only.
- Up elements run A = 0..N-1; down elements run A = N-1..0. The element boundary has no gap cycle.
- Start: start=1 at an edge while in IDLE or DONE begins the test next cycle.
  - busy=1, done=0, fail=0.
  - fail_addr, fail_elem and fail_data clear to 0.
  - start while busy=1 is ignored.
- M0: one cycle per cell with mem_we=1, mem_addr=A, mem_wdata=Z. N cycles in total.
- M1-M4: two cycles per cell.
  - RD cycle: mem_re=1, mem_addr=A.
  - CMP cycle: mem_rdata is compared with the expected background; mem_we=1, mem_addr=A, mem_wdata = element write value.
  - The CMP write is always performed, even on a mismatch.
- M5: two cycles per cell, RD then CMP with no write.
- Total run length is 11N cycles; N=16 gives 176.
- mem_we and mem_re are never both 1 in the same cycle. Outside a run, mem_we, mem_re, mem_addr and mem_wdata are 0.
- Pass: the cycle after the final M5 CMP (A = N-1), state DONE with busy=0, done=1, fail=0.
- Fail (stop on first mismatch): the cycle after a failing CMP, state DONE with busy=0, done=1, fail=1.
  - fail_addr = A, fail_elem = E, fail_data = mem_rdata sampled in that CMP cycle.
  - No further memory accesses occur.
- Address arithmetic is modulo 2**AD_W. The up/down terminal is detected by comparison with N-1 or 0, not by carry-out.
- DONE holds all result outputs until start or reset.

Test Plan:
- Fault-free RAM model, AD_W=4, DATA_W=8, start pulse at edge k -> busy=1 in cycles k+1..k+176; done=1, fail=0 from k+177; 16 M0 writes of 0x00 at addresses 0..15, in order.
- Address-order check on the same run -> M3 and M4 RD addresses go 15,14,...,0; M5 goes 0..15; mem_we and mem_re are never both high.
- RAM model with address 5 bit 3 stuck-at-1 -> fail in M1: fail=1, fail_elem=1, fail_addr=5, fail_data=0x08; no mem_we or mem_re after that CMP.
- RAM model with address 0 bit 0 stuck-at-0 -> M0 and M1 pass; fail_elem=2, fail_addr=0, fail_data=0xFE.
- reset asserted for one cycle at k+50 of a run -> all outputs 0 the next cycle; a new start gives a clean pass at start+177.
- start pulsed at k+20 during a run -> ignored, pass still at k+177; start held high in DONE -> a new run begins with done=0 the next cycle.
